// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the register-read stage.
package pipe_pkg;

  localparam logic [0:3] REG_RAX = 4'd0;
  localparam logic [0:3] REG_RDX = 4'd2;
  localparam logic [0:3] REG_RSP = 4'd4;

  localparam logic [0:7] OP_MULDIV = 8'd247;
  localparam logic [0:7] OP_GRP5   = 8'd255;
  localparam logic [0:7] OP_CALL   = 8'd232;
  localparam logic [0:7] OP_RET    = 8'd195;
  localparam logic [0:7] OP_MOV_ST = 8'd137;
  localparam logic [0:7] OP_MOV_LD = 8'd139;

  // Decode -> register-read bundle.
  typedef struct packed {
    logic [0:63] pc;
    logic [0:7]  opcode;
    logic [0:3]  regByte;
    logic [0:3]  rmByte;
    logic        use_a;
    logic        use_b;
    logic        dst_en;
    logic [0:3]  dst;
    logic        dst2_en;
    logic        rsp_en;
  } ID_RR;

  // Register-read -> execute bundle.
  typedef struct packed {
    logic [0:63] pc;
    logic [0:7]  opcode;
    logic [0:3]  regByte;
    logic [0:3]  rmByte;
    logic [0:63] opa;
    logic [0:63] opb;
    logic [0:63] rsp;
  } RR_EX;

  // Register read with same-cycle writeback forwarding; port 1 has priority.
  function automatic logic [0:63] wb_bypass(
    input logic [0:3]  idx,
    input logic [0:63] rf_val,
    input logic        en0,
    input logic [0:3]  idx0,
    input logic [0:63] d0,
    input logic        en1,
    input logic [0:3]  idx1,
    input logic [0:63] d1
  );
    if (en1 && idx1 == idx) return d1;
    if (en0 && idx0 == idx) return d0;
    return rf_val;
  endfunction

endpackage

// File: rtl/mod_scoreboard.sv
// Busy scoreboard: tracks in-flight destinations and flags decode hazards.
module mod_scoreboard
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       accept,
  input  logic       use_a,
  input  logic [0:3] src_a,
  input  logic       use_b,
  input  logic [0:3] src_b,
  input  logic       dst_en,
  input  logic [0:3] dst,
  input  logic       dst2_en,
  input  logic       rsp_en,
  input  logic       wb_en0,
  input  logic [0:3] wb_idx0,
  input  logic       wb_en1,
  input  logic [0:3] wb_idx1,
  output logic       hazard
);

  logic [0:15] busy;
  logic [0:15] clr;
  logic [0:15] set;
  logic [0:15] live;

  // Bits cleared by this cycle's writebacks and set by an accepted bundle.
  always_comb begin
    clr = '0;
    set = '0;
    if (wb_en0) clr[wb_idx0] = 1'b1;
    if (wb_en1) clr[wb_idx1] = 1'b1;
    if (accept) begin
      if (dst_en)  set[dst]     = 1'b1;
      if (dst2_en) set[REG_RDX] = 1'b1;
      if (rsp_en)  set[REG_RSP] = 1'b1;
    end
  end

  assign live = busy & ~clr;

  // Any referenced register still in flight after same-cycle writebacks stalls decode.
  always_comb begin
    hazard = (use_a   && live[src_a])   ||
             (use_b   && live[src_b])   ||
             (dst_en  && live[dst])     ||
             (dst2_en && live[REG_RDX]) ||
             (rsp_en  && live[REG_RSP]);
  end

  // Set overrides clear for the same bit; flush empties the scoreboard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      busy <= '0;
    else if (flush) busy <= '0;
    else            busy <= live | set;
  end

endmodule

// File: rtl/mod_regread.sv
// Register-read / operand-fetch stage: register file, bypass, output register.
module mod_regread
  import pipe_pkg::*;
#(
  parameter logic [0:63] RSP_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [0:63] dec_pc,
  input  logic [0:7]  dec_opcode,
  input  logic [0:3]  dec_regByte,
  input  logic [0:3]  dec_rmByte,
  input  logic        dec_use_a,
  input  logic        dec_use_b,
  input  logic        dec_dst_en,
  input  logic [0:3]  dec_dst,
  input  logic        dec_dst2_en,
  input  logic        dec_rsp_en,
  input  logic        wb_en0,
  input  logic [0:3]  wb_idx0,
  input  logic [0:63] wb_data0,
  input  logic        wb_en1,
  input  logic [0:3]  wb_idx1,
  input  logic [0:63] wb_data1,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [0:63] ex_opa,
  output logic [0:63] ex_opb,
  output logic [0:63] ex_rsp,
  output logic [0:63] ex_pc,
  output logic [0:7]  ex_opcode,
  output logic [0:3]  ex_regByte,
  output logic [0:3]  ex_rmByte
);

  ID_RR        id;
  RR_EX        out_q;
  RR_EX        out_d;
  logic        valid_q;
  logic        hazard;
  logic        accept;
  logic [0:63] rf [0:15];

  assign id = '{pc: dec_pc, opcode: dec_opcode, regByte: dec_regByte,
                rmByte: dec_rmByte, use_a: dec_use_a, use_b: dec_use_b,
                dst_en: dec_dst_en, dst: dec_dst, dst2_en: dec_dst2_en,
                rsp_en: dec_rsp_en};

  mod_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .accept  (accept),
    .use_a   (id.use_a),
    .src_a   (id.regByte),
    .use_b   (id.use_b),
    .src_b   (id.rmByte),
    .dst_en  (id.dst_en),
    .dst     (id.dst),
    .dst2_en (id.dst2_en),
    .rsp_en  (id.rsp_en),
    .wb_en0  (wb_en0),
    .wb_idx0 (wb_idx0),
    .wb_en1  (wb_en1),
    .wb_idx1 (wb_idx1),
    .hazard  (hazard)
  );

  assign dec_ready = !hazard && (!valid_q || ex_ready) && !flush;
  assign accept    = dec_valid && dec_ready;

  // Next output bundle: bypassed operand reads, unused operands forced to zero.
  always_comb begin
    out_d.pc      = id.pc;
    out_d.opcode  = id.opcode;
    out_d.regByte = id.regByte;
    out_d.rmByte  = id.rmByte;
    out_d.opa     = id.use_a ? wb_bypass(id.regByte, rf[id.regByte], wb_en0, wb_idx0,
                                         wb_data0, wb_en1, wb_idx1, wb_data1) : '0;
    out_d.opb     = id.use_b ? wb_bypass(id.rmByte, rf[id.rmByte], wb_en0, wb_idx0,
                                         wb_data0, wb_en1, wb_idx1, wb_data1) : '0;
    out_d.rsp     = wb_bypass(REG_RSP, rf[REG_RSP], wb_en0, wb_idx0,
                              wb_data0, wb_en1, wb_idx1, wb_data1);
  end

  // Register file; port 1 is written last so it wins on an index collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++)
        rf[i] <= (i == 32'(REG_RSP)) ? RSP_INIT : '0;
    end else begin
      if (wb_en0) rf[wb_idx0] <= wb_data0;
      if (wb_en1) rf[wb_idx1] <= wb_data1;
    end
  end

  // Output register with valid/ready handshake toward execute.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      out_q   <= out_d;
    end else if (ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_opa     = out_q.opa;
  assign ex_opb     = out_q.opb;
  assign ex_rsp     = out_q.rsp;
  assign ex_pc      = out_q.pc;
  assign ex_opcode  = out_q.opcode;
  assign ex_regByte = out_q.regByte;
  assign ex_rmByte  = out_q.rmByte;

endmodule

// File: tb/tb_mod_regread.sv
// Self-checking bench for mod_regread: directed scenarios plus randomized traffic.
module tb_mod_regread;

  logic        clk = 1'b0;
  logic        reset, flush, dec_valid, dec_ready;
  logic [0:63] dec_pc;
  logic [0:7]  dec_opcode;
  logic [0:3]  dec_regByte, dec_rmByte, dec_dst;
  logic        dec_use_a, dec_use_b, dec_dst_en, dec_dst2_en, dec_rsp_en;
  logic        wb_en0, wb_en1;
  logic [0:3]  wb_idx0, wb_idx1;
  logic [0:63] wb_data0, wb_data1;
  logic        ex_valid, ex_ready;
  logic [0:63] ex_opa, ex_opb, ex_rsp, ex_pc;
  logic [0:7]  ex_opcode;
  logic [0:3]  ex_regByte, ex_rmByte;

  always #5 clk = ~clk;

  mod_regread #(.RSP_INIT(64'h1000)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_opcode(dec_opcode), .dec_regByte(dec_regByte), .dec_rmByte(dec_rmByte),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_dst_en(dec_dst_en),
    .dec_dst(dec_dst), .dec_dst2_en(dec_dst2_en), .dec_rsp_en(dec_rsp_en),
    .wb_en0(wb_en0), .wb_idx0(wb_idx0), .wb_data0(wb_data0),
    .wb_en1(wb_en1), .wb_idx1(wb_idx1), .wb_data1(wb_data1),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opa(ex_opa), .ex_opb(ex_opb),
    .ex_rsp(ex_rsp), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
    .ex_regByte(ex_regByte), .ex_rmByte(ex_rmByte)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: architectural registers, in-flight set, output bundle.
  logic [63:0] m_rf [16];
  bit          m_busy [16];
  bit          m_valid;
  logic [63:0] m_opa, m_opb, m_rsp, m_pc;
  logic [7:0]  m_opc;
  logic [3:0]  m_reg, m_rm;

  task automatic m_reset();
    foreach (m_rf[i]) m_rf[i] = (i == 4) ? 64'h1000 : 64'h0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_valid = 1'b0;
    m_opa = '0; m_opb = '0; m_rsp = '0; m_pc = '0;
    m_opc = '0; m_reg = '0; m_rm = '0;
  endtask

  function automatic bit written(int r);
    return (wb_en0 && int'(wb_idx0) == r) || (wb_en1 && int'(wb_idx1) == r);
  endfunction

  function automatic bit stalled(int r);
    return m_busy[r] && !written(r);
  endfunction

  function automatic logic [63:0] rd(int r);
    if (wb_en1 && int'(wb_idx1) == r) return wb_data1;
    if (wb_en0 && int'(wb_idx0) == r) return wb_data0;
    return m_rf[r];
  endfunction

  task automatic idle();
    flush = 0; dec_valid = 0; dec_pc = '0; dec_opcode = '0;
    dec_regByte = '0; dec_rmByte = '0; dec_use_a = 0; dec_use_b = 0;
    dec_dst_en = 0; dec_dst = '0; dec_dst2_en = 0; dec_rsp_en = 0;
    wb_en0 = 0; wb_idx0 = '0; wb_data0 = '0;
    wb_en1 = 0; wb_idx1 = '0; wb_data1 = '0;
    ex_ready = 1;
  endtask

  task automatic dec(input logic [7:0] opc, input bit ua, input int ra,
                     input bit ub, input int rb, input bit de, input int d,
                     input bit d2, input bit rs);
    dec_valid = 1; dec_pc = {$urandom, $urandom}; dec_opcode = opc;
    dec_use_a = ua; dec_regByte = 4'(ra); dec_use_b = ub; dec_rmByte = 4'(rb);
    dec_dst_en = de; dec_dst = 4'(d); dec_dst2_en = d2; dec_rsp_en = rs;
  endtask

  task automatic check_outputs();
    chk("ex_valid",   64'(ex_valid),   64'(m_valid));
    chk("ex_opa",     ex_opa,          m_opa);
    chk("ex_opb",     ex_opb,          m_opb);
    chk("ex_rsp",     ex_rsp,          m_rsp);
    chk("ex_pc",      ex_pc,           m_pc);
    chk("ex_opcode",  64'(ex_opcode),  64'(m_opc));
    chk("ex_regByte", 64'(ex_regByte), 64'(m_reg));
    chk("ex_rmByte",  64'(ex_rmByte),  64'(m_rm));
  endtask

  // One clock: inputs already driven after a falling edge.
  task automatic cyc();
    bit haz, er, acc;
    logic [63:0] va, vb, vs;
    #1;
    haz = (dec_use_a && stalled(int'(dec_regByte))) ||
          (dec_use_b && stalled(int'(dec_rmByte))) ||
          (dec_dst_en && stalled(int'(dec_dst))) ||
          (dec_dst2_en && stalled(2)) ||
          (dec_rsp_en && stalled(4));
    er  = !haz && (!m_valid || ex_ready) && !flush;
    chk("dec_ready", 64'(dec_ready), 64'(er));
    acc = dec_valid && er;
    va  = dec_use_a ? rd(int'(dec_regByte)) : 64'h0;
    vb  = dec_use_b ? rd(int'(dec_rmByte)) : 64'h0;
    vs  = rd(4);
    @(posedge clk);
    if (wb_en0) m_rf[wb_idx0] = wb_data0;
    if (wb_en1) m_rf[wb_idx1] = wb_data1;
    if (flush) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_valid = 1'b0;
    end else begin
      if (wb_en0) m_busy[wb_idx0] = 1'b0;
      if (wb_en1) m_busy[wb_idx1] = 1'b0;
      if (acc) begin
        if (dec_dst_en)  m_busy[dec_dst] = 1'b1;
        if (dec_dst2_en) m_busy[2] = 1'b1;
        if (dec_rsp_en)  m_busy[4] = 1'b1;
        m_valid = 1'b1;
        m_opa = va; m_opb = vb; m_rsp = vs; m_pc = dec_pc;
        m_opc = dec_opcode; m_reg = dec_regByte; m_rm = dec_rmByte;
      end else if (ex_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    int r;
    idle();
    m_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    check_outputs();
    chk("ready_after_reset", 64'(dec_ready), 64'd1);
    reset = 0;

    // First bundle sees RSP_INIT; destination 3 goes in flight.
    dec(pipe_pkg::OP_MOV_LD, 1, 1, 1, 5, 1, 3, 0, 0);
    cyc();
    chk("rsp_init", ex_rsp, 64'h1000);

    // Read of r3 stalls until its writeback, then accepts through the bypass.
    idle(); dec(pipe_pkg::OP_MOV_ST, 0, 0, 1, 3, 0, 0, 0, 0);
    cyc(); cyc();
    wb_en0 = 1; wb_idx0 = 4'd3; wb_data0 = 64'hAB;
    cyc();
    chk("opb_bypass", ex_opb, 64'hAB);

    // Dual-destination op; both ports retire it in one cycle.
    idle(); dec(pipe_pkg::OP_MULDIV, 0, 0, 1, 1, 1, 0, 1, 0);
    cyc();
    idle();
    wb_en0 = 1; wb_idx0 = 4'd0; wb_data0 = 64'd5;
    wb_en1 = 1; wb_idx1 = 4'd2; wb_data1 = 64'd7;
    cyc();
    idle(); dec(pipe_pkg::OP_MOV_LD, 1, 0, 1, 2, 0, 0, 0, 0);
    cyc();
    chk("rax_after_wb", ex_opa, 64'd5);
    chk("rdx_after_wb", ex_opb, 64'd7);

    // Back-pressure from execute holds the bundle and blocks decode.
    idle(); dec(pipe_pkg::OP_MOV_LD, 1, 6, 0, 0, 0, 0, 0, 0);
    cyc();
    ex_ready = 0; dec(pipe_pkg::OP_MOV_LD, 1, 7, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    ex_ready = 1;
    cyc();

    // Push then pop: the pop waits for the RSP writeback.
    idle(); dec(pipe_pkg::OP_GRP5, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc();
    idle(); dec(pipe_pkg::OP_RET, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(); cyc();
    wb_en1 = 1; wb_idx1 = 4'd4; wb_data1 = 64'hFF8;
    cyc();
    chk("pop_rsp", ex_rsp, 64'hFF8);

    // Flush with r1/RSP in flight and a held bundle; a same-cycle write survives.
    idle(); wb_en1 = 1; wb_idx1 = 4'd4; wb_data1 = 64'hFF0;
    cyc();
    idle(); ex_ready = 0; dec(pipe_pkg::OP_CALL, 0, 0, 0, 0, 1, 1, 0, 1);
    cyc();
    idle(); ex_ready = 0; flush = 1;
    wb_en0 = 1; wb_idx0 = 4'd9; wb_data0 = 64'h123;
    cyc();
    chk("flush_valid", 64'(ex_valid), 64'd0);
    idle(); dec(pipe_pkg::OP_MOV_LD, 1, 9, 1, 1, 1, 1, 0, 1);
    cyc();
    chk("flush_keeps_write", ex_opa, 64'h123);

    // Randomized traffic with a reset dropped in mid-stream.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        idle();
        #2 reset = 1;
        #1;
        m_reset();
        check_outputs();
        @(negedge clk);
        reset = 0;
      end
      idle();
      dec_valid   = ($urandom_range(9, 0) < 7);
      dec_pc      = {$urandom, $urandom};
      case ($urandom_range(5, 0))
        0: dec_opcode = pipe_pkg::OP_MULDIV;
        1: dec_opcode = pipe_pkg::OP_GRP5;
        2: dec_opcode = pipe_pkg::OP_CALL;
        3: dec_opcode = pipe_pkg::OP_RET;
        4: dec_opcode = pipe_pkg::OP_MOV_ST;
        default: dec_opcode = pipe_pkg::OP_MOV_LD;
      endcase
      dec_regByte = 4'($urandom_range(15, 0));
      dec_rmByte  = 4'($urandom_range(15, 0));
      dec_use_a   = 1'($urandom_range(1, 0));
      dec_use_b   = 1'($urandom_range(1, 0));
      dec_dst_en  = 1'($urandom_range(1, 0));
      dec_dst     = 4'($urandom_range(15, 0));
      dec_dst2_en = (dec_opcode == pipe_pkg::OP_MULDIV) && ($urandom_range(1, 0) == 1);
      dec_rsp_en  = ($urandom_range(9, 0) < 2);
      for (int t = 0; t < 4 && !wb_en0; t++) begin
        r = int'($urandom_range(15, 0));
        if (m_busy[r] || $urandom_range(7, 0) == 0) begin
          wb_en0 = 1; wb_idx0 = 4'(r); wb_data0 = {$urandom, $urandom};
        end
      end
      r = ($urandom_range(3, 0) == 0) ? int'(wb_idx0) :
          ($urandom_range(1, 0) == 1) ? 2 : 4;
      if (m_busy[r] || $urandom_range(5, 0) == 0) begin
        wb_en1 = 1; wb_idx1 = 4'(r); wb_data1 = {$urandom, $urandom};
      end
      flush    = ($urandom_range(31, 0) == 0);
      ex_ready = ($urandom_range(3, 0) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
